sram_arb: RTL

SRAM_ARB -- requirements
Module: sram_arb

---
 rtl/sram_arb_pkg.sv | 14 +
 rtl/sram_arb_if.sv | 57 +++++
 rtl/sram_arb_rr_arb2.sv | 37 +++
 rtl/sram_arb.sv | 79 +++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// rtl/sram_arb_pkg.sv - shared state encoding and port index constants for sram_arb
package sram_arb_pkg;

   // IDLE: no read response outstanding; RESP: response valid, waiting for ready
   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RESP = 1'b1
   } state_t;

   // Port indices used for the round-robin pointer and response ownership
   localparam logic PORT_P0 = 1'b0;
   localparam logic PORT_P1 = 1'b1;

endpackage

// File: rtl/sram_arb_if.sv
// rtl/sram_arb_if.sv - requester ports and sram-side bus bundled for sram_arb
interface sram_arb_if #(
   parameter int DEPTH = 1024
);
   localparam int LOGDEPTH = $clog2(DEPTH);

   // port 0 (fetch, read only)
   logic                p0_req;
   logic [LOGDEPTH-1:0] p0_addr;
   logic                p0_gnt;
   logic                p0_rsp_valid;
   logic [31:0]         p0_rsp_data;
   logic                p0_rsp_ready;

   // port 1 (data, read/write)
   logic                p1_req;
   logic                p1_we;
   logic [LOGDEPTH-1:0] p1_addr;
   logic [3:0]          p1_byte_en;
   logic [31:0]         p1_wdata;
   logic                p1_gnt;
   logic                p1_rsp_valid;
   logic [31:0]         p1_rsp_data;
   logic                p1_rsp_ready;

   // sram side
   logic                mem_read_req;
   logic [LOGDEPTH-1:0] mem_read_addr;
   logic [31:0]         mem_read_data;
   logic                mem_write_req;
   logic [LOGDEPTH-1:0] mem_write_addr;
   logic [3:0]          mem_write_byte_en;
   logic [31:0]         mem_write_data;

   // arbiter view
   modport slave (
      input  p0_req, p0_addr, p0_rsp_ready,
      output p0_gnt, p0_rsp_valid, p0_rsp_data,
      input  p1_req, p1_we, p1_addr, p1_byte_en, p1_wdata, p1_rsp_ready,
      output p1_gnt, p1_rsp_valid, p1_rsp_data,
      output mem_read_req, mem_read_addr,
      input  mem_read_data,
      output mem_write_req, mem_write_addr, mem_write_byte_en, mem_write_data
   );

   // requester and sram environment view
   modport master (
      output p0_req, p0_addr, p0_rsp_ready,
      input  p0_gnt, p0_rsp_valid, p0_rsp_data,
      output p1_req, p1_we, p1_addr, p1_byte_en, p1_wdata, p1_rsp_ready,
      input  p1_gnt, p1_rsp_valid, p1_rsp_data,
      input  mem_read_req, mem_read_addr,
      output mem_read_data,
      input  mem_write_req, mem_write_addr, mem_write_byte_en, mem_write_data
   );

endinterface

// File: rtl/sram_arb_rr_arb2.sv
// rtl/sram_arb_rr_arb2.sv - two-way round-robin grant with last-winner pointer
module rr_arb2
   import sram_arb_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_en,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

   logic r_last;

   // Grant one requester when enabled; on a tie the port not granted last wins
   always_comb begin
      o_gnt = 2'b00;
      if (i_en) begin
         if (i_req[0] && i_req[1]) begin
            o_gnt = (r_last == PORT_P1) ? 2'b01 : 2'b10;
         end else begin
            o_gnt = i_req;
         end
      end
   end

   // Remember the most recent winner; reset makes p0 win the first tie
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= PORT_P1;
      end else if (o_gnt[0]) begin
         r_last <= PORT_P0;
      end else if (o_gnt[1]) begin
         r_last <= PORT_P1;
      end
   end

endmodule

// File: rtl/sram_arb.sv
// rtl/sram_arb.sv - two-port round-robin arbiter in front of a single-port-pair sram
module sram_arb
   import sram_arb_pkg::*;
#(
   parameter int DEPTH = 1024
) (
   input  logic       clk,
   input  logic       reset_n,
   sram_arb_if.slave  bus
);

   localparam int LOGDEPTH = $clog2(DEPTH);

   state_t              r_state;
   logic                r_owner;
   logic                r_p0_vld;
   logic                r_p1_vld;

   logic                w_owner_ready;
   logic                w_slot;
   logic [1:0]          w_gnt;
   logic                w_p1_rd;
   logic                w_p1_wr;
   logic                w_rd;
   logic [LOGDEPTH-1:0] w_rd_addr;

   // The held response must be accepted before anyone else may use the sram
   assign w_owner_ready = (r_owner == PORT_P0) ? bus.p0_rsp_ready : bus.p1_rsp_ready;
   assign w_slot        = reset_n && ((r_state == ST_IDLE) || w_owner_ready);

   rr_arb2 u_rr (
      .clk   (clk),
      .rst_n (reset_n),
      .i_en  (w_slot),
      .i_req ({bus.p1_req, bus.p0_req}),
      .o_gnt (w_gnt)
   );

   assign bus.p0_gnt = w_gnt[0];
   assign bus.p1_gnt = w_gnt[1];

   assign w_p1_rd   = w_gnt[1] & ~bus.p1_we;
   assign w_p1_wr   = w_gnt[1] &  bus.p1_we;
   assign w_rd      = w_gnt[0] | w_p1_rd;
   assign w_rd_addr = w_p1_rd ? bus.p1_addr : bus.p0_addr;

   assign bus.mem_read_req      = w_rd;
   assign bus.mem_read_addr     = w_rd_addr;
   assign bus.mem_write_req     = w_p1_wr;
   assign bus.mem_write_addr    = bus.p1_addr;
   assign bus.mem_write_byte_en = bus.p1_byte_en;
   assign bus.mem_write_data    = bus.p1_wdata;

   // The sram holds its read data while no read is issued, so it can be forwarded directly
   assign bus.p0_rsp_valid = r_p0_vld;
   assign bus.p1_rsp_valid = r_p1_vld;
   assign bus.p0_rsp_data  = r_p0_vld ? bus.mem_read_data : 32'h0;
   assign bus.p1_rsp_data  = r_p1_vld ? bus.mem_read_data : 32'h0;

   // Response FSM: enter RESP after any granted read, leave once the owner accepts
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= ST_IDLE;
         r_owner  <= PORT_P0;
         r_p0_vld <= 1'b0;
         r_p1_vld <= 1'b0;
      end else if (w_rd) begin
         r_state  <= ST_RESP;
         r_owner  <= w_p1_rd ? PORT_P1 : PORT_P0;
         r_p0_vld <= ~w_p1_rd;
         r_p1_vld <= w_p1_rd;
      end else if ((r_state == ST_RESP) && w_owner_ready) begin
         r_state  <= ST_IDLE;
         r_p0_vld <= 1'b0;
         r_p1_vld <= 1'b0;
      end
   end

endmodule
